// File: rtl/stream_demux_1to2_pkg.sv
// ----------------------------------------------------------------------------
// stream_demux_1to2_pkg
//
// Purpose: shared constants and types for the 1:2 stream demultiplexer and
// its per-port 2-entry FIFO.
//
// Contents:
//   DEMUX_WIDTH   default payload width in bits
//   DEMUX_DEPTH   entries held by each output buffer
//   PORT0/PORT1   select values steering a transfer to output 0 or 1
//   fifo_count_t  occupancy counter type (holds 0..DEMUX_DEPTH)
//   FIFO_FULL     occupancy value at which a buffer refuses pushes
// ----------------------------------------------------------------------------
package stream_demux_1to2_pkg;

  localparam int DEMUX_WIDTH = 16;
  localparam int DEMUX_DEPTH = 2;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef logic [1:0] fifo_count_t;

  localparam fifo_count_t FIFO_FULL = fifo_count_t'(DEMUX_DEPTH);

endpackage

// File: rtl/demux_fifo2.sv
// ----------------------------------------------------------------------------
// demux_fifo2
//
// Purpose: 2-entry first-in first-out buffer used as the output stage of
// each port of the stream demultiplexer. Storage is registered and the head
// entry is presented directly from storage, so a pushed word is visible
// one cycle after the push.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset, empties buffer, clears data
//   push_i   in   write data_i at the tail (ignored while full)
//   data_i   in   payload to write
//   full_o   out  buffer holds DEMUX_DEPTH entries
//   pop_i    in   consumer takes the head entry (ignored while empty)
//   valid_o  out  buffer holds at least one entry
//   data_o   out  head entry payload
// ----------------------------------------------------------------------------
module demux_fifo2
  import stream_demux_1to2_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] mem_q [DEMUX_DEPTH];
  logic             wrPtr_q;
  logic             wrPtr_d;
  logic             rdPtr_q;
  logic             rdPtr_d;
  fifo_count_t      count_q;
  fifo_count_t      count_d;
  logic             pushEn;
  logic             popEn;

  // The buffer protects itself: a push while full or a pop while empty is
  // dropped here, so the caller never corrupts occupancy by mistake.
  always_comb begin
    pushEn = push_i & ~full_o;
    popEn  = pop_i & valid_o;
  end

  // Next-state for pointers and occupancy. With one slot per pointer value
  // the pointers simply toggle, which is the 1->0 wrap. A push and a pop in
  // the same cycle leave occupancy unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q ^ pushEn;
    rdPtr_d = rdPtr_q ^ popEn;
    count_d = count_q;
    case ({pushEn, popEn})
      2'b10:   count_d = count_q + fifo_count_t'(1);
      2'b01:   count_d = count_q - fifo_count_t'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers. Reset throws away whatever was held and zeroes the
  // storage so the head payload reads 0 while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= 1'b0;
      rdPtr_q <= 1'b0;
      count_q <= '0;
      for (int i = 0; i < DEMUX_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (pushEn) begin
        mem_q[wrPtr_q] <= data_i;
      end
    end
  end

  // Status and head payload come straight from registered state.
  always_comb begin
    full_o  = (count_q == FIFO_FULL);
    valid_o = (count_q != '0);
    data_o  = mem_q[rdPtr_q];
  end

endmodule

// File: rtl/stream_demux_1to2.sv
// ----------------------------------------------------------------------------
// stream_demux_1to2
//
// Purpose: steers one valid/ready input stream to one of two output streams,
// chosen per transfer by in_sel_i. Each output has its own 2-entry buffer so
// a stalled consumer only blocks traffic headed for its own port.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   in_valid_i    in   producer holds a transfer
//   in_ready_o    out  transfer accepted this cycle when valid & ready
//   in_sel_i      in   destination: PORT0 or PORT1
//   in_data_i     in   payload
//   out0_valid_o  out  port 0 head entry valid
//   out0_ready_i  in   port 0 consumer accepts head
//   out0_data_o   out  port 0 head payload
//   out1_valid_o  out  port 1 head entry valid
//   out1_ready_i  in   port 1 consumer accepts head
//   out1_data_o   out  port 1 head payload
// ----------------------------------------------------------------------------
module stream_demux_1to2
  import stream_demux_1to2_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_sel_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out0_valid_o,
  input  logic             out0_ready_i,
  output logic [WIDTH-1:0] out0_data_o,
  output logic             out1_valid_o,
  input  logic             out1_ready_i,
  output logic [WIDTH-1:0] out1_data_o
);

  logic full0;
  logic full1;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;

  // Ready looks only at the fullness of the selected port, never at the
  // consumer's ready, so a full port refuses a push even when it is being
  // drained in the same cycle. This keeps in_ready free of any path from
  // the output side.
  always_comb begin
    in_ready_o = (in_sel_i == PORT1) ? ~full1 : ~full0;
  end

  // Only the selected port sees the accepted transfer; both ports may pop
  // independently every cycle.
  always_comb begin
    push0 = in_valid_i & in_ready_o & (in_sel_i == PORT0);
    push1 = in_valid_i & in_ready_o & (in_sel_i == PORT1);
    pop0  = out0_valid_o & out0_ready_i;
    pop1  = out1_valid_o & out1_ready_i;
  end

  demux_fifo2 #(
    .WIDTH (WIDTH)
  ) port0Fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push0),
    .data_i  (in_data_i),
    .full_o  (full0),
    .pop_i   (pop0),
    .valid_o (out0_valid_o),
    .data_o  (out0_data_o)
  );

  demux_fifo2 #(
    .WIDTH (WIDTH)
  ) port1Fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push1),
    .data_i  (in_data_i),
    .full_o  (full1),
    .pop_i   (pop1),
    .valid_o (out1_valid_o),
    .data_o  (out1_data_o)
  );

endmodule
